// File: rtl/spi_seq_pkg.sv
// ----------------------------------------------------------------------------
// spi_seq_pkg
//   Shared definitions for the SPI burst sequencer:
//     - BYTE_W      : width of one SPI byte
//     - ST_*        : sequencer FSM state encodings (IDLE .. CS_HOLD)
//     - cnt_width() : width of the CS setup/hold gap counter
//   Build option: SPI_SEQ_RX_FIFO_EN (used by spi_burst_sequencer) selects
//   an RX FIFO instead of the single RX holding register.
// ----------------------------------------------------------------------------
package spi_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CS_SETUP  = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_CS_HOLD   = 3'd5;

    // One extra bit over $clog2 so the terminal count itself always fits.
    function automatic int cnt_width(input int setup_clks, input int hold_clks);
        int longest;
        longest = (setup_clks > hold_clks) ? setup_clks : hold_clks;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// ----------------------------------------------------------------------------
// spi_seq_fifo
//   Synchronous first-word-fall-through FIFO with asynchronous active-low
//   reset. rd_data always shows the head entry while empty is low.
//   Ports:
//     clk, rst_n     clock, async active-low reset (empties the FIFO)
//     push, wr_data  write request and data; dropped when full unless a pop
//                    is honoured in the same cycle
//     pop            read request; ignored when empty
//     rd_data        head entry
//     full, empty    status
//   Parameters: WIDTH (data bits), DEPTH (entries, power of two >= 2).
// ----------------------------------------------------------------------------
module spi_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra MSB so full and empty are distinguishable
    // when the address bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a push on a
    // full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// ----------------------------------------------------------------------------
// spi_burst_sequencer
//   Feeds an SPI byte master: queues CPU TX bytes, issues them back-to-back
//   as single-cycle TX_DV pulses whenever the master is ready, collects RX
//   bytes and owns chip-select with programmable setup/hold gaps.
//   Ports:
//     i_Clk, i_Rst_L            clock, async active-low reset
//     i_Wr_Byte, i_Wr_DV        TX byte push        o_Wr_Full   TX FIFO full
//     i_Start                   start burst pulse   o_Busy      burst in progress
//     i_Rd_En                   RX pop              o_Rd_Byte   RX head byte
//     o_Rd_Empty                no RX byte          o_RX_Overflow sticky drop flag
//     i_Clr_Flags               clears o_RX_Overflow
//     o_TX_Byte, o_TX_DV        to master           i_TX_Ready  from master
//     i_RX_DV, i_RX_Byte        from master         o_SPI_CS_n  chip select
//   Build option SPI_SEQ_RX_FIFO_EN:
//     defined     - RX bytes go into a FIFO_DEPTH-entry FIFO.
//     not defined - one RX holding register; o_Rd_Empty is low while it holds
//                   an unread byte, a new byte overwrites it.
//   Handshake: o_TX_DV is high for exactly one cycle with o_TX_Byte valid in
//   that cycle; the next byte is only issued after i_TX_Ready has dropped and
//   returned high.
// ----------------------------------------------------------------------------
module spi_burst_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [BYTE_W-1:0] i_Wr_Byte,
    input  logic              i_Wr_DV,
    output logic              o_Wr_Full,
    input  logic              i_Start,
    output logic              o_Busy,
    input  logic              i_Rd_En,
    output logic [BYTE_W-1:0] o_Rd_Byte,
    output logic              o_Rd_Empty,
    output logic              o_RX_Overflow,
    input  logic              i_Clr_Flags,
    output logic [BYTE_W-1:0] o_TX_Byte,
    output logic              o_TX_DV,
    input  logic              i_TX_Ready,
    input  logic              i_RX_DV,
    input  logic [BYTE_W-1:0] i_RX_Byte,
    output logic              o_SPI_CS_n
);

    localparam int CW = cnt_width(CS_SETUP_CLKS, CS_HOLD_CLKS);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic              tx_empty;
    logic              tx_full;
    logic [BYTE_W-1:0] tx_head;
    logic              tx_pop;
    logic              rx_drop;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    spi_seq_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (i_Clk),
        .rst_n   (i_Rst_L),
        .push    (i_Wr_DV),
        .wr_data (i_Wr_Byte),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign o_Wr_Full = tx_full;

    // A byte is issued on the edge that enters LOAD, so o_TX_DV is high
    // during the LOAD cycle itself and CS setup spans exactly
    // CS_SETUP_CLKS cycles before it. WAIT_DONE re-loads directly when the
    // master is ready again and more bytes (including ones written during
    // the burst) are queued.
    assign tx_pop = !tx_empty &&
                    (((state == ST_CS_SETUP) && (cnt == SETUP_LAST)) ||
                     ((state == ST_WAIT_DONE) && i_TX_Ready));

    // ------------------------------------------------------------------
    // Burst FSM and chip-select timing
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_SPI_CS_n <= 1'b1;
            o_Busy     <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= '0;
        end else begin
            o_TX_DV <= 1'b0;
            if (tx_pop) begin
                o_TX_Byte <= tx_head;
                o_TX_DV   <= 1'b1;
                state     <= ST_LOAD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A start with nothing queued or a busy master is dropped.
                        if (i_Start && !tx_empty && i_TX_Ready) begin
                            state      <= ST_CS_SETUP;
                            cnt        <= '0;
                            o_SPI_CS_n <= 1'b0;
                            o_Busy     <= 1'b1;
                        end
                    end
                    ST_CS_SETUP: begin
                        // Reaching the terminal count with an empty FIFO can
                        // only follow an abnormal state; close the burst.
                        if (cnt == SETUP_LAST) begin
                            state <= ST_CS_HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ST_LOAD: begin
                        state <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        // Master lowers ready one cycle after DV; skip one cycle
                        // so the still-high ready is not mistaken for completion.
                        state <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        if (i_TX_Ready) begin
                            state <= ST_CS_HOLD;
                            cnt   <= '0;
                        end
                    end
                    ST_CS_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state      <= ST_IDLE;
                            o_SPI_CS_n <= 1'b1;
                            o_Busy     <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        o_SPI_CS_n <= 1'b1;
                        o_Busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
`ifdef SPI_SEQ_RX_FIFO_EN
    logic rx_full;
    logic rx_empty;

    spi_seq_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (i_Clk),
        .rst_n   (i_Rst_L),
        .push    (i_RX_DV),
        .wr_data (i_RX_Byte),
        .pop     (i_Rd_En),
        .rd_data (o_Rd_Byte),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign o_Rd_Empty = rx_empty;
    // A pop in the same cycle makes room, so nothing is lost then.
    assign rx_drop    = i_RX_DV && rx_full && !i_Rd_En;
`else
    logic [BYTE_W-1:0] rx_reg;
    logic              rx_valid;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_reg   <= '0;
            rx_valid <= 1'b0;
        end else if (i_RX_DV) begin
            rx_reg   <= i_RX_Byte;
            rx_valid <= 1'b1;
        end else if (i_Rd_En) begin
            rx_valid <= 1'b0;
        end
    end

    assign o_Rd_Byte  = rx_reg;
    assign o_Rd_Empty = !rx_valid;
    // Overwriting an unread byte loses it, unless it is read this cycle.
    assign rx_drop    = i_RX_DV && rx_valid && !i_Rd_En;
`endif

    // Sticky overflow; a new drop wins over a clear in the same cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_RX_Overflow <= 1'b0;
        end else if (rx_drop) begin
            o_RX_Overflow <= 1'b1;
        end else if (i_Clr_Flags) begin
            o_RX_Overflow <= 1'b0;
        end
    end

endmodule
